// File: rtl/pwm_capture_if.sv
// PWM capture bundle: sample tick and line in,
// measured duty/period with a publish strobe out.
interface pwm_capture_if #(
  parameter int FF_BITS  = 8,
  parameter int PER_BITS = 10
);
  logic                ce;
  logic                pwm_in;
  logic [FF_BITS-1:0]  fill_factor;
  logic [PER_BITS-1:0] period;
  logic                stuck;
  logic                valid;

  modport master (
    output ce, pwm_in,
    input  fill_factor, period, stuck, valid
  );

  modport slave (
    input  ce, pwm_in,
    output fill_factor, period, stuck, valid
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM decoder: measures active ticks and period between
// active edges on CE ticks; reports stuck lines on timeout.
module pwm_capture #(
  parameter bit ACT_STATE            = 1'b1,
  parameter int FILL_FACTOR_MAX      = 255,
  parameter int FILL_FACTOR_BITS_NUM = $clog2(FILL_FACTOR_MAX),
  parameter int PERIOD_MAX           = 1023,
  parameter int PERIOD_BITS_NUM      = $clog2(PERIOD_MAX + 1)
) (
  input logic           clk,
  input logic           clr,
  pwm_capture_if.slave  bus
);

  localparam int FB = FILL_FACTOR_BITS_NUM;
  localparam int PB = PERIOD_BITS_NUM;

  localparam logic [PB-1:0] PMAX = PB'(PERIOD_MAX);
  localparam logic [PB-1:0] CMAX = '1;
  localparam logic [PB-1:0] ONE  = PB'(1);
  localparam logic [FB-1:0] FMAX = FB'(FILL_FACTOR_MAX);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [PB-1:0] act_cnt;
  logic [PB-1:0] per_cnt;

  logic          a;
  logic          rise;
  logic          timeout;
  logic [PB-1:0] per_inc;
  logic [PB-1:0] act_inc;
  logic [FB-1:0] ff_sat;
  logic [FB-1:0] ff_stuck;

  // Sync FFs run every clk; only they move while CE is low.
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1 <= ACT_STATE;
      sync2 <= ACT_STATE;
    end else begin
      sync1 <= bus.pwm_in;
      sync2 <= sync1;
    end
  end

  assign a    = ACT_STATE ? sync2 : ~sync2;
  assign rise = bus.ce & a & ~prev;

  assign per_inc = (per_cnt == CMAX) ?
                   per_cnt : per_cnt + ONE;
  assign act_inc = (a && act_cnt != CMAX) ?
                   act_cnt + ONE : act_cnt;

  assign timeout = (per_inc >= PMAX);

  assign ff_sat = (32'(act_cnt) > FILL_FACTOR_MAX) ?
                  FMAX : FB'(act_cnt);
  assign ff_stuck = a ? FMAX : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      state           <= IDLE;
      prev            <= 1'b1;
      act_cnt         <= '0;
      per_cnt         <= '0;
      bus.fill_factor <= '0;
      bus.period      <= '0;
      bus.stuck       <= 1'b0;
      bus.valid       <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      if (bus.ce) begin
        prev <= a;
        unique case (state)
          IDLE: begin
            if (rise) begin
              state   <= MEASURE;
              act_cnt <= ONE;
              per_cnt <= ONE;
            end else if (timeout) begin
              bus.fill_factor <= ff_stuck;
              bus.period      <= '0;
              bus.stuck       <= 1'b1;
              bus.valid       <= 1'b1;
              per_cnt         <= '0;
            end else begin
              per_cnt <= per_inc;
            end
          end
          MEASURE: begin
            // A rise on the timeout tick still closes the period.
            if (rise) begin
              bus.fill_factor <= ff_sat;
              bus.period      <= per_cnt;
              bus.stuck       <= 1'b0;
              bus.valid       <= 1'b1;
              act_cnt         <= ONE;
              per_cnt         <= ONE;
            end else if (timeout) begin
              bus.fill_factor <= ff_stuck;
              bus.period      <= '0;
              bus.stuck       <= 1'b1;
              bus.valid       <= 1'b1;
              state           <= IDLE;
              per_cnt         <= '0;
            end else begin
              per_cnt <= per_inc;
              act_cnt <= act_inc;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: two decoders (active-high and
// active-low) on one line, checked against a tick-level model.
module tb_pwm_capture;

  localparam int FMAX = 255;
  localparam int PMAX = 1023;
  localparam int FB   = 8;
  localparam int PB   = 10;
  localparam int HN   = 2048;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic ce  = 1'b0;
  logic pwm = 1'b0;

  always #5 clk = ~clk;

  pwm_capture_if #(.FF_BITS(FB), .PER_BITS(PB)) b0 ();
  pwm_capture_if #(.FF_BITS(FB), .PER_BITS(PB)) b1 ();

  assign b0.ce     = ce;
  assign b0.pwm_in = pwm;
  assign b1.ce     = ce;
  assign b1.pwm_in = pwm;

  pwm_capture #(.ACT_STATE(1'b1)) dut0 (
    .clk(clk), .clr(clr), .bus(b0)
  );
  pwm_capture #(.ACT_STATE(1'b0)) dut1 (
    .clk(clk), .clr(clr), .bus(b1)
  );

  int chk  = 0;
  int errs = 0;

  // Model: per decoder, history of sampled active levels.
  bit hist [2][HN];
  int k;
  int base  [2];
  int lrise [2];
  bit meas  [2];
  bit prv   [2];
  int e_ff  [2];
  int e_per [2];
  bit e_st  [2];
  bit e_v   [2];

  logic [41:0] obs;
  logic [41:0] expv;

  task automatic model_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      base[d] = -1; lrise[d] = 0; meas[d] = 1'b0;
      prv[d] = 1'b1; e_ff[d] = 0; e_per[d] = 0;
      e_st[d] = 1'b0; e_v[d] = 1'b0;
    end
  endtask

  task automatic model_step(input int d, input bit a);
    int s;
    e_v[d] = 1'b0;
    hist[d][k % HN] = a;
    if (a && !prv[d]) begin
      if (meas[d]) begin
        s = 0;
        for (int i = lrise[d]; i < k; i++)
          s += int'(hist[d][i % HN]);
        e_ff[d]  = (s > FMAX) ? FMAX : s;
        e_per[d] = k - lrise[d];
        e_st[d]  = 1'b0;
        e_v[d]   = 1'b1;
      end
      meas[d] = 1'b1; lrise[d] = k; base[d] = k - 1;
    end else if (k - base[d] == PMAX) begin
      e_ff[d]  = a ? FMAX : 0;
      e_per[d] = 0;
      e_st[d]  = 1'b1;
      e_v[d]   = 1'b1;
      meas[d]  = 1'b0;
      base[d]  = k;
    end
    prv[d] = a;
  endtask

  // One CE tick: 3 clk, line stable 2 clk before the CE edge.
  task automatic tick(input bit lvl);
    bit [1:0] late;
    ce  = 1'b0;
    pwm = lvl;
    @(negedge clk);
    late = {b1.valid, b0.valid};
    @(negedge clk);
    late |= {b1.valid, b0.valid};
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    model_step(0, lvl);
    model_step(1, !lvl);
    k++;
    obs = {late[0], b0.valid, b0.stuck, b0.period, b0.fill_factor,
           late[1], b1.valid, b1.stuck, b1.period, b1.fill_factor};
    expv = {1'b0, e_v[0], e_st[0], PB'(e_per[0]), FB'(e_ff[0]),
            1'b0, e_v[1], e_st[1], PB'(e_per[1]), FB'(e_ff[1])};
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(negedge clk);
    chk++;
    if ({b0.valid, b0.stuck, b0.period, b0.fill_factor,
         b1.valid, b1.stuck, b1.period, b1.fill_factor} !== '0) begin
      errs++;
      $display("FAIL reset: got %h %h %h %h want 0",
               b0.fill_factor, b0.period, b0.stuck, b0.valid);
    end
    clr = 1'b0;
    model_reset();
  endtask

  task automatic test_loopback();
    for (int p = 0; p < 4; p++)
      for (int t = 0; t < 255; t++) begin
        tick(t < 64);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL loopback k=%0d got %h want %h", k, obs, expv);
        end
      end
    chk++;
    if ({b0.fill_factor, b0.period, b0.stuck} !== {8'd64, 10'd255, 1'b0}) begin
      errs++;
      $display("FAIL loopback_final got ff=%0d per=%0d st=%0d want 64 255 0",
               b0.fill_factor, b0.period, b0.stuck);
    end
  endtask

  task automatic test_stuck();
    int n1 = 0;
    int n0 = 0;
    for (int t = 0; t < 2100; t++) begin
      tick(1'b1);
      if (b0.valid && b0.stuck && b0.fill_factor == 8'd255) n1++;
      chk++;
      if (obs !== expv) begin
        errs++;
        $display("FAIL stuck_hi k=%0d got %h want %h", k, obs, expv);
      end
    end
    chk++;
    if (n1 !== 2) begin
      errs++;
      $display("FAIL stuck_hi_count got %0d want 2", n1);
    end
    for (int t = 0; t < 1100; t++) begin
      tick(1'b0);
      if (b0.valid && b0.stuck && b0.fill_factor == 8'd0) n0++;
      chk++;
      if (obs !== expv) begin
        errs++;
        $display("FAIL stuck_lo k=%0d got %h want %h", k, obs, expv);
      end
    end
    chk++;
    if (n0 !== 1 || b0.period !== 10'd0) begin
      errs++;
      $display("FAIL stuck_lo_count got %0d per=%0d want 1 0", n0, b0.period);
    end
  endtask

  task automatic test_act_low();
    for (int p = 0; p < 5; p++)
      for (int t = 0; t < 40; t++) begin
        tick(t >= 10);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL act_low k=%0d got %h want %h", k, obs, expv);
        end
      end
    chk++;
    if ({b1.fill_factor, b1.period} !== {8'd10, 10'd40}) begin
      errs++;
      $display("FAIL act_low_final got ff=%0d per=%0d want 10 40",
               b1.fill_factor, b1.period);
    end
  endtask

  task automatic test_saturate();
    for (int p = 0; p < 3; p++)
      for (int t = 0; t < 400; t++) begin
        tick(t < 300);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL saturate k=%0d got %h want %h", k, obs, expv);
        end
      end
    chk++;
    if ({b0.fill_factor, b0.period} !== {8'd255, 10'd400}) begin
      errs++;
      $display("FAIL saturate_final got ff=%0d per=%0d want 255 400",
               b0.fill_factor, b0.period);
    end
  endtask

  task automatic test_timeout_edge();
    bit [1:0] lv [$];
    bit race = 1'b0;
    for (int i = 0; i < 1100; i++) lv.push_back(0);
    lv.push_back(1);
    for (int i = 0; i < 1021; i++) lv.push_back(0);
    lv.push_back(1);
    for (int i = 0; i < 1022; i++) lv.push_back(0);
    lv.push_back(1);
    for (int i = 0; i < 5; i++) lv.push_back(0);
    lv.push_back(1);
    lv.push_back(1);
    foreach (lv[i]) begin
      tick(lv[i][0]);
      if (i == 1100 + 1 + 1021 && b0.valid && !b0.stuck &&
          b0.period == 10'd1022 && b0.fill_factor == 8'd1)
        race = 1'b1;
      chk++;
      if (obs !== expv) begin
        errs++;
        $display("FAIL timeout_edge k=%0d got %h want %h", k, obs, expv);
      end
    end
    chk++;
    if (!race) begin
      errs++;
      $display("FAIL rise_wins got race=0 want 1 (per=1022 ff=1)");
    end
    chk++;
    if ({b0.fill_factor, b0.period, b0.stuck} !== {8'd1, 10'd6, 1'b0}) begin
      errs++;
      $display("FAIL after_timeout got ff=%0d per=%0d st=%0d want 1 6 0",
               b0.fill_factor, b0.period, b0.stuck);
    end
  endtask

  task automatic test_ce_hold();
    for (int p = 0; p < 4; p++) begin
      for (int t = 0; t < 35; t++) begin
        tick(t < 15);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL ce_hold k=%0d got %h want %h", k, obs, expv);
        end
        if (p == 1 && t == 7) begin
          for (int c = 0; c < 50; c++) begin
            ce  = 1'b0;
            pwm = 1'($urandom);
            @(negedge clk);
            chk++;
            if ({b0.valid, b1.valid, b0.period, b0.fill_factor} !==
                {2'b00, PB'(e_per[0]), FB'(e_ff[0])}) begin
              errs++;
              $display("FAIL ce_low c=%0d got v=%b%b per=%0d ff=%0d want 00 %0d %0d",
                       c, b0.valid, b1.valid, b0.period, b0.fill_factor,
                       e_per[0], e_ff[0]);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int hi;
    int lo;
    for (int s = 0; s < 12; s++) begin
      hi = (s % 4 == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, 300));
      lo = (s == 5) ? 1100 : int'($urandom_range(1, 300));
      for (int t = 0; t < hi + lo; t++) begin
        tick(t < hi);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL random k=%0d got %h want %h", k, obs, expv);
        end
      end
    end
  endtask

  task automatic test_clr_mid();
    for (int t = 0; t < 135; t++) tick((t % 50) < 20);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk++;
    if ({b0.valid, b0.stuck, b0.period, b0.fill_factor,
         b1.valid, b1.stuck, b1.period, b1.fill_factor} !== '0) begin
      errs++;
      $display("FAIL clr_mid got ff=%0d per=%0d st=%0d want 0 0 0",
               b0.fill_factor, b0.period, b0.stuck);
    end
    model_reset();
    for (int p = 0; p < 3; p++)
      for (int t = 0; t < 50; t++) begin
        tick(t >= 20);
        chk++;
        if (obs !== expv) begin
          errs++;
          $display("FAIL clr_resume k=%0d got %h want %h", k, obs, expv);
        end
      end
    chk++;
    if ({b0.fill_factor, b0.period} !== {8'd30, 10'd50}) begin
      errs++;
      $display("FAIL clr_first got ff=%0d per=%0d want 30 50",
               b0.fill_factor, b0.period);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_stuck();
    test_act_low();
    test_saturate();
    test_timeout_edge();
    test_ce_hold();
    test_random();
    test_clr_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             chk, errs);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
